// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the uart_rx_checker slice.
// Holds the receiver state enum, oversampling constants and default dividers.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP1,
        S_STOP2
    } state_t;

    localparam int OVS   = 16;
    localparam int SMP_A = 7;
    localparam int SMP_B = 8;
    localparam int SMP_C = 9;

    localparam int DEF_DIV_9600 = 326;
    localparam int DEF_DIV_2400 = 1302;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// uart_rx_tick_gen: oversample tick generator, one-cycle tick every DIV clocks.
// Ports: clk, rst (async high), clr (sync clear), sel_9600 (divider select), tick.
module uart_rx_tick_gen #(
    parameter int DIV_9600 = 326,
    parameter int DIV_2400 = 1302
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic sel_9600,
    output logic tick
);

    logic [15:0] cnt;
    logic [15:0] lim;

    assign lim  = sel_9600 ? 16'(DIV_9600 - 1) : 16'(DIV_2400 - 1);
    assign tick = (cnt == lim) && !clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_rx_checker.sv
// uart_rx_checker: 16x oversampled UART receiver with alternating-pattern check.
// Ports: clk, rst (async high), rxd, sel_8bit, sel_2stop, sel_9600 in;
// data[7:0], data_valid, frame_err, pattern_err, busy out.
// Optional: define UART_RX_PATTERN_CHECK_EN to build the pattern checker.
module uart_rx_checker
    import uart_rx_pkg::*;
#(
    parameter int DIV_9600 = DEF_DIV_9600,
    parameter int DIV_2400 = DEF_DIV_2400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       sel_8bit,
    input  logic       sel_2stop,
    input  logic       sel_9600,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       pattern_err,
    output logic       busy
);

    state_t      state, state_n;
    logic        rxd_s1, rxd_s2, rxd_d;
    logic        fall;
    logic        tick, clr;
    logic [3:0]  scnt, scnt_n;
    logic [2:0]  bcnt, bcnt_n;
    logic [7:0]  shreg, shreg_n;
    logic [1:0]  smp, smp_n;
    logic        cfg_8bit, cfg_2stop, cfg_9600;
    logic        cfg_8bit_n, cfg_2stop_n, cfg_9600_n;
    logic [7:0]  word;
    logic        vote, done, fe_n;

    // rxd_d is the previous synchronized value, used only for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_d  <= 1'b1;
        end else begin
            rxd_s1 <= rxd;
            rxd_s2 <= rxd_s1;
            rxd_d  <= rxd_s2;
        end
    end

    assign fall = rxd_d & ~rxd_s2;
    assign busy = (state != S_IDLE);

    uart_rx_tick_gen #(
        .DIV_9600 (DIV_9600),
        .DIV_2400 (DIV_2400)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .sel_9600 (cfg_9600),
        .tick     (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            scnt       <= '0;
            bcnt       <= '0;
            shreg      <= '0;
            smp        <= '0;
            cfg_8bit   <= 1'b0;
            cfg_2stop  <= 1'b0;
            cfg_9600   <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            scnt       <= scnt_n;
            bcnt       <= bcnt_n;
            shreg      <= shreg_n;
            smp        <= smp_n;
            cfg_8bit   <= cfg_8bit_n;
            cfg_2stop  <= cfg_2stop_n;
            cfg_9600   <= cfg_9600_n;
            data_valid <= done;
            frame_err  <= fe_n;
            if (done) begin
                data <= word;
            end
        end
    end

    // Each bit: samples at ticks 7/8 are stored, the vote is taken at tick 9
    // and acted on immediately; the bit ends after tick 15.
    always_comb begin
        state_n     = state;
        scnt_n      = scnt;
        bcnt_n      = bcnt;
        shreg_n     = shreg;
        smp_n       = smp;
        cfg_8bit_n  = cfg_8bit;
        cfg_2stop_n = cfg_2stop;
        cfg_9600_n  = cfg_9600;
        clr         = 1'b0;
        done        = 1'b0;
        fe_n        = 1'b0;
        vote        = maj3(smp[0], smp[1], rxd_s2);
        // 7-bit frames leave the character one place high in the shifter.
        word        = cfg_8bit ? shreg : {1'b0, shreg[7:1]};

        unique case (state)
            S_IDLE: begin
                if (fall) begin
                    state_n     = S_START;
                    clr         = 1'b1;
                    scnt_n      = '0;
                    bcnt_n      = '0;
                    cfg_8bit_n  = sel_8bit;
                    cfg_2stop_n = sel_2stop;
                    cfg_9600_n  = sel_9600;
                end
            end
            default: begin
                if (tick) begin
                    scnt_n = scnt + 4'd1;
                    if (scnt == 4'(SMP_A)) smp_n[0] = rxd_s2;
                    if (scnt == 4'(SMP_B)) smp_n[1] = rxd_s2;
                    if (scnt == 4'(SMP_C)) begin
                        unique case (state)
                            S_START: if (vote) state_n = S_IDLE;
                            S_DATA:  shreg_n = {vote, shreg[7:1]};
                            S_STOP1: begin
                                if (!vote) begin
                                    fe_n    = 1'b1;
                                    state_n = S_IDLE;
                                end else if (!cfg_2stop) begin
                                    done = 1'b1;
                                end
                            end
                            S_STOP2: begin
                                if (!vote) begin
                                    fe_n    = 1'b1;
                                    state_n = S_IDLE;
                                end else begin
                                    done = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    if (scnt == 4'(OVS - 1)) begin
                        unique case (state)
                            S_START: begin
                                state_n = S_DATA;
                                bcnt_n  = '0;
                            end
                            S_DATA: begin
                                if (bcnt == (cfg_8bit ? 3'd7 : 3'd6)) begin
                                    state_n = S_STOP1;
                                end else begin
                                    bcnt_n = bcnt + 3'd1;
                                end
                            end
                            S_STOP1: state_n = S_STOP2;
                            default: ;
                        endcase
                    end
                end
            end
        endcase

        if (done) state_n = S_IDLE;
    end

`ifdef UART_RX_PATTERN_CHECK_EN
    logic exp_ones;

    // Expected character alternates 0x00 / all-ones after every good frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_ones    <= 1'b0;
            pattern_err <= 1'b0;
        end else begin
            pattern_err <= done &&
                (word != (exp_ones ? (cfg_8bit ? 8'hFF : 8'h7F) : 8'h00));
            if (done) exp_ones <= ~exp_ones;
        end
    end
`else
    assign pattern_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_checker.sv
// tb_uart_rx_checker: directed frames with a scoreboard of expected strobes.
// Monitor pops one entry per data_valid/frame_err event and compares it.
module tb_uart_rx_checker;

    localparam int D96 = 10;
    localparam int D24 = 24;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       sel_8bit = 1'b1;
    logic       sel_2stop = 1'b0;
    logic       sel_9600 = 1'b1;
    logic [7:0] data;
    logic       data_valid, frame_err, pattern_err, busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       dv;
        logic [7:0] d;
        logic       pe;
    } ev_t;

    ev_t sb[$];
    logic exp_m = 1'b0;

    uart_rx_checker #(
        .DIV_9600 (D96),
        .DIV_2400 (D24)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .sel_8bit    (sel_8bit),
        .sel_2stop   (sel_2stop),
        .sel_9600    (sel_9600),
        .data        (data),
        .data_valid  (data_valid),
        .frame_err   (frame_err),
        .pattern_err (pattern_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_dv(input logic [7:0] d, input bit b8);
        ev_t e;
        logic [7:0] want;
        e.dv = 1'b1;
        e.d  = b8 ? d : {1'b0, d[6:0]};
        want = exp_m ? (b8 ? 8'hFF : 8'h7F) : 8'h00;
`ifdef UART_RX_PATTERN_CHECK_EN
        e.pe = (e.d != want);
`else
        e.pe = 1'b0;
`endif
        exp_m = ~exp_m;
        sb.push_back(e);
    endtask

    task automatic push_fe();
        ev_t e;
        e.dv = 1'b0;
        e.d  = 8'h00;
        e.pe = 1'b0;
        sb.push_back(e);
    endtask

    // One bit cell; optional short inverted spike around sample tick 8.
    task automatic drive_bit(input logic v, input int div, input bit spike);
        rxd = v;
        if (spike) begin
            repeat (9 * div - 3) @(negedge clk);
            rxd = ~v;
            repeat (7) @(negedge clk);
            rxd = v;
            repeat (16 * div - 9 * div - 4) @(negedge clk);
        end else begin
            repeat (16 * div) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input int ns,
                              input bit bad_stop, input int spike_bit);
        int div;
        div = sel_9600 ? D96 : D24;
        drive_bit(1'b0, div, 1'b0);
        for (int i = 0; i < nb; i++) drive_bit(d[i], div, i == spike_bit);
        drive_bit(!bad_stop, div, 1'b0);
        if (ns == 2) drive_bit(1'b1, div, 1'b0);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && (data_valid || frame_err || pattern_err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe",
                    {29'd0, data_valid, frame_err, pattern_err}, 32'd0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("data_valid", {31'd0, data_valid}, {31'd0, e.dv});
                chk("frame_err", {31'd0, frame_err}, {31'd0, ~e.dv});
                if (e.dv) chk("data", {24'd0, data}, {24'd0, e.d});
                chk("pattern_err", {31'd0, pattern_err}, {31'd0, e.pe});
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_data", {24'd0, data}, 32'd0);
        chk("rst_dv", {31'd0, data_valid}, 32'd0);
        chk("rst_fe", {31'd0, frame_err}, 32'd0);
        chk("rst_pe", {31'd0, pattern_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 9600 8N1: 0x00 then 0xFF
        sel_9600 = 1'b1; sel_8bit = 1'b1; sel_2stop = 1'b0;
        push_dv(8'h00, 1'b1); send_frame(8'h00, 8, 1, 1'b0, -1);
        push_dv(8'hFF, 1'b1); send_frame(8'hFF, 8, 1, 1'b0, -1);

        // 2400 7N2: 0x00, 0x7F, 0x7F
        sel_9600 = 1'b0; sel_8bit = 1'b0; sel_2stop = 1'b1;
        push_dv(8'h00, 1'b0); send_frame(8'h00, 7, 2, 1'b0, -1);
        push_dv(8'h7F, 1'b0); send_frame(8'h7F, 7, 2, 1'b0, -1);
        push_dv(8'h7F, 1'b0); send_frame(8'h7F, 7, 2, 1'b0, -1);

        // 9600 framing error, then a good 0x00
        sel_9600 = 1'b1; sel_8bit = 1'b1; sel_2stop = 1'b0;
        push_fe(); send_frame(8'h55, 8, 1, 1'b1, -1);
        push_dv(8'h00, 1'b1); send_frame(8'h00, 8, 1, 1'b0, -1);

        // false start from a short low glitch
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        chk("glitch_busy_hi", {31'd0, busy}, 32'd1);
        repeat (40) @(negedge clk);
        rxd = 1'b1;
        repeat (100) @(negedge clk);
        chk("glitch_busy_lo", {31'd0, busy}, 32'd0);
        repeat (100) @(negedge clk);

        // 0xA5 with spike in data bit 2
        push_dv(8'hA5, 1'b1); send_frame(8'hA5, 8, 1, 1'b0, 2);

        // reset in the middle of a frame
        drive_bit(1'b0, D96, 1'b0);
        drive_bit(1'b1, D96, 1'b0);
        rxd = 1'b0;
        repeat (8 * D96) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_data", {24'd0, data}, 32'd0);
        chk("mid_rst_dv", {31'd0, data_valid}, 32'd0);
        chk("mid_rst_fe", {31'd0, frame_err}, 32'd0);
        chk("mid_rst_pe", {31'd0, pattern_err}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        exp_m = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        rst = 1'b0;
        repeat (40 * D96) @(negedge clk);
        push_dv(8'h00, 1'b1); send_frame(8'h00, 8, 1, 1'b0, -1);

        repeat (200) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        chk("end_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
